// File: rtl/rx_link_release_ctrl_if.sv
// rx_link_release_ctrl_if
//   Bundles the LMFC timing, lane/link configuration, lane status and the
//   per-link / per-lane release outputs of rx_link_release_ctrl.
//   master : the environment (LMFC generator, software, lane data paths).
//   slave  : the release controller itself.
//   Signals (direction seen from the controller):
//     lmfc_counter_i    in  8          beat index within the multiframe
//     release_delay_i   in  LINKS*8    per-link release beat
//     lane_link_map_i   in  L*LIW      link index per lane (>= LINKS disables)
//     lane_enable_i     in  L          per-lane enable
//     buffer_ready_ni   in  L          per-lane buffer ready, active-low
//     link_reset_i      in  LINKS      per-link resynchronisation request
//     err_clr_i         in  1          clear sticky errors and counters
//     buffer_release_no out LINKS      per-link release, active-low
//     lane_release_no   out L          per-lane release, active-low
//     link_valid_o      out LINKS      link data valid
//     release_err_o     out LINKS      sticky error flag
//     release_err_cnt_o out LINKS*CNT_W saturating error count
//     link_state_o      out LINKS*2    FSM state per link
interface rx_link_release_ctrl_if #(
   parameter int L     = 2,
   parameter int LINKS = 1,
   parameter int CNT_W = 8
);
   localparam int LIW = (LINKS > 1) ? $clog2(LINKS) : 1;

   logic [7:0]             lmfc_counter_i;
   logic [LINKS*8-1:0]     release_delay_i;
   logic [L*LIW-1:0]       lane_link_map_i;
   logic [L-1:0]           lane_enable_i;
   logic [L-1:0]           buffer_ready_ni;
   logic [LINKS-1:0]       link_reset_i;
   logic                   err_clr_i;
   logic [LINKS-1:0]       buffer_release_no;
   logic [L-1:0]           lane_release_no;
   logic [LINKS-1:0]       link_valid_o;
   logic [LINKS-1:0]       release_err_o;
   logic [LINKS*CNT_W-1:0] release_err_cnt_o;
   logic [LINKS*2-1:0]     link_state_o;

   modport master (
      output lmfc_counter_i, release_delay_i, lane_link_map_i, lane_enable_i,
             buffer_ready_ni, link_reset_i, err_clr_i,
      input  buffer_release_no, lane_release_no, link_valid_o, release_err_o,
             release_err_cnt_o, link_state_o
   );

   modport slave (
      input  lmfc_counter_i, release_delay_i, lane_link_map_i, lane_enable_i,
             buffer_ready_ni, link_reset_i, err_clr_i,
      output buffer_release_no, lane_release_no, link_valid_o, release_err_o,
             release_err_cnt_o, link_state_o
   );
endinterface

// File: rtl/rx_link_release_ctrl.sv
// rx_link_release_ctrl
//   Per-link elastic-buffer release controller for a JESD204B receiver.
//   Each of LINKS links gathers its member lanes through a runtime lane map
//   and lane enables, waits for all members to report buffer ready, and
//   releases them together on its programmed LMFC beat. A link that cannot
//   release within TIMEOUT_MF multiframes, or that loses a lane after
//   release, goes to ERROR and is recorded in a sticky flag and a
//   saturating counter.
//   Ports:
//     clk_i  in  clock
//     rst_i  in  asynchronous active-high reset
//     bus    rx_link_release_ctrl_if.slave (see the interface file)
//
//   Release/valid relationship: buffer_release_no[k] low means the member
//   lane buffers of link k may drain; link_valid_o[k] follows it one cycle
//   later so downstream logic sees data only once the buffers are running.
//   There is no back-pressure path: the controller never waits on a consumer.
module rx_link_release_ctrl #(
   parameter int L          = 2,
   parameter int LINKS      = 1,
   parameter int TIMEOUT_MF = 4,
   parameter int CNT_W      = 8
) (
   input logic                  clk_i,
   input logic                  rst_i,
   rx_link_release_ctrl_if.slave bus
);
   localparam int LIW = (LINKS > 1) ? $clog2(LINKS) : 1;
   // Value of the timeout counter on which the next wrap declares a timeout.
   localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT_MF - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT     = 2'd1,
      ST_RELEASED = 2'd2,
      ST_ERROR    = 2'd3
   } state_t;

   state_t           state_q   [LINKS];
   state_t           state_d   [LINKS];
   logic [7:0]       tmo_q     [LINKS];
   logic [7:0]       tmo_d     [LINKS];
   logic [CNT_W-1:0] cnt_q     [LINKS];
   logic [L-1:0]     member    [LINKS];

   logic [LINKS-1:0] all_rdy;
   logic [LINKS-1:0] any_rdy;
   logic [LINKS-1:0] link_empty;
   logic [LINKS-1:0] opp_q;
   logic             wrap_q;
   logic [LINKS-1:0] err_entry;
   logic [LINKS-1:0] err_q;
   logic [LINKS-1:0] valid_q;
   logic [LINKS-1:0] brn;
   logic [L-1:0]     lane_rel_n;
   logic [LINKS*2-1:0]     state_vec;
   logic [LINKS*CNT_W-1:0] cnt_vec;

   // ------------------------------------------------------------------
   // Lane membership and per-link readiness. A map value that matches no
   // link index (>= LINKS) simply makes the lane a member of nothing.
   // ------------------------------------------------------------------
   always_comb begin
      all_rdy    = '0;
      any_rdy    = '0;
      link_empty = '0;
      for (int k = 0; k < LINKS; k++) begin
         member[k] = '0;
         for (int l = 0; l < L; l++) begin
            member[k][l] = bus.lane_enable_i[l] &&
                           (bus.lane_link_map_i[l*LIW +: LIW] == LIW'(k));
         end
         link_empty[k] = ~|member[k];
         any_rdy[k]    = |(member[k] & ~bus.buffer_ready_ni);
         all_rdy[k]    = ~link_empty[k] && ((member[k] & bus.buffer_ready_ni) == '0);
      end
   end

   // ------------------------------------------------------------------
   // Registered LMFC pulses. A delay beyond the multiframe length never
   // matches, so such a link can only leave WAIT through the timeout.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         opp_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         for (int k = 0; k < LINKS; k++) begin
            opp_q[k] <= (bus.lmfc_counter_i == bus.release_delay_i[k*8 +: 8]);
         end
         wrap_q <= (bus.lmfc_counter_i == 8'd0);
      end
   end

   // ------------------------------------------------------------------
   // Per-link FSM: next state, timeout counter and error-entry detection.
   // ------------------------------------------------------------------
   always_comb begin
      err_entry = '0;
      for (int k = 0; k < LINKS; k++) begin
         state_d[k] = state_q[k];
         tmo_d[k]   = '0;
         if (bus.link_reset_i[k]) begin
            state_d[k] = ST_IDLE;
         end else begin
            case (state_q[k])
               ST_IDLE: begin
                  if (opp_q[k] && all_rdy[k]) begin
                     state_d[k] = ST_RELEASED;
                  end else if (any_rdy[k]) begin
                     state_d[k] = ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  // Release is checked first so it wins over a timeout on
                  // the same beat.
                  if (opp_q[k] && all_rdy[k]) begin
                     state_d[k] = ST_RELEASED;
                  end else if (!any_rdy[k]) begin
                     state_d[k] = ST_IDLE;
                  end else begin
                     tmo_d[k] = tmo_q[k];
                     if (wrap_q) begin
                        if (tmo_q[k] == TMO_LAST) begin
                           state_d[k] = ST_ERROR;
                        end else begin
                           tmo_d[k] = tmo_q[k] + 8'd1;
                        end
                     end
                  end
               end
               ST_RELEASED: begin
                  // An emptied link is a reconfiguration, not a lane loss.
                  if (link_empty[k]) begin
                     state_d[k] = ST_IDLE;
                  end else if (!all_rdy[k]) begin
                     state_d[k] = ST_ERROR;
                  end
               end
               ST_ERROR: begin
                  if (!any_rdy[k]) begin
                     state_d[k] = ST_IDLE;
                  end
               end
               default: state_d[k] = ST_IDLE;
            endcase
         end
         err_entry[k] = (state_d[k] == ST_ERROR) && (state_q[k] != ST_ERROR);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < LINKS; k++) begin
            state_q[k] <= ST_IDLE;
            tmo_q[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < LINKS; k++) begin
            state_q[k] <= state_d[k];
            tmo_q[k]   <= tmo_d[k];
         end
      end
   end

   // ------------------------------------------------------------------
   // Error recording. A clear coinciding with a new ERROR entry keeps that
   // entry: flag set, count restarts at one.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= '0;
         for (int k = 0; k < LINKS; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < LINKS; k++) begin
            if (bus.err_clr_i) begin
               err_q[k] <= err_entry[k];
               cnt_q[k] <= err_entry[k] ? CNT_ONE : '0;
            end else if (err_entry[k]) begin
               err_q[k] <= 1'b1;
               if (cnt_q[k] != CNT_MAX) begin
                  cnt_q[k] <= cnt_q[k] + CNT_ONE;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs. Release comes straight from the state register; valid is
   // that release delayed by one flop.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else begin
         valid_q <= ~brn;
      end
   end

   always_comb begin
      brn       = '1;
      state_vec = '0;
      cnt_vec   = '0;
      for (int k = 0; k < LINKS; k++) begin
         brn[k]                    = (state_q[k] != ST_RELEASED);
         state_vec[k*2 +: 2]       = state_q[k];
         cnt_vec[k*CNT_W +: CNT_W] = cnt_q[k];
      end
   end

   // A lane is a member of at most one link, so at most one term matches.
   always_comb begin
      lane_rel_n = '1;
      for (int l = 0; l < L; l++) begin
         for (int k = 0; k < LINKS; k++) begin
            if (member[k][l]) begin
               lane_rel_n[l] = brn[k];
            end
         end
      end
   end

   assign bus.buffer_release_no = brn;
   assign bus.lane_release_no   = lane_rel_n;
   assign bus.link_valid_o      = valid_q;
   assign bus.release_err_o     = err_q;
   assign bus.release_err_cnt_o = cnt_vec;
   assign bus.link_state_o      = state_vec;

endmodule

// File: tb/tb_rx_link_release_ctrl.sv
// tb_rx_link_release_ctrl
//   Drives rx_link_release_ctrl with directed scenarios and randomized
//   episodes and compares every cycle against a behavioural model that
//   follows the link rules (membership counts, multiframe beats, error
//   bookkeeping) directly.
module tb_rx_link_release_ctrl;
   localparam int L          = 4;
   localparam int LINKS      = 2;
   localparam int TIMEOUT_MF = 4;
   localparam int CNT_W      = 2;
   localparam int LIW        = (LINKS > 1) ? $clog2(LINKS) : 1;
   localparam int PERIOD     = 8;
   localparam int CNT_SAT    = (1 << CNT_W) - 1;
   localparam int P_IDLE = 0, P_WAIT = 1, P_REL = 2, P_ERR = 3;
   localparam int W = LINKS*2 + LINKS + L + LINKS + LINKS + LINKS*CNT_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rx_link_release_ctrl_if #(.L(L), .LINKS(LINKS), .CNT_W(CNT_W)) bus ();

   rx_link_release_ctrl #(
      .L(L), .LINKS(LINKS), .TIMEOUT_MF(TIMEOUT_MF), .CNT_W(CNT_W)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [W-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int m_phase [LINKS];
   int m_tmo   [LINKS];
   int m_cnt   [LINKS];
   bit m_err   [LINKS];
   bit m_valid [LINKS];
   bit m_opp   [LINKS];
   bit m_wrap;

   task automatic model_reset();
      for (int k = 0; k < LINKS; k++) begin
         m_phase[k] = P_IDLE; m_tmo[k] = 0; m_cnt[k] = 0;
         m_err[k] = 0; m_valid[k] = 0; m_opp[k] = 0;
      end
      m_wrap = 0;
      exp_q.delete();
   endtask

   function automatic int lane_link(int l);
      if (!bus.lane_enable_i[l]) return -1;
      if (int'(bus.lane_link_map_i[l*LIW +: LIW]) >= LINKS) return -1;
      return int'(bus.lane_link_map_i[l*LIW +: LIW]);
   endfunction

   // Applies one clock edge to the model using the inputs present at it,
   // then queues the outputs expected just after the edge.
   task automatic model_step();
      logic [LINKS*2-1:0]     e_state;
      logic [LINKS-1:0]       e_brn, e_valid, e_err;
      logic [L-1:0]           e_lane;
      logic [LINKS*CNT_W-1:0] e_cnt;
      for (int k = 0; k < LINKS; k++) begin
         int  members = 0, ready = 0, old;
         bit  all_r, any_r;
         for (int l = 0; l < L; l++) begin
            if (lane_link(l) == k) begin
               members++;
               if (!bus.buffer_ready_ni[l]) ready++;
            end
         end
         all_r = (members > 0) && (ready == members);
         any_r = (ready > 0);
         m_valid[k] = (m_phase[k] == P_REL);
         old = m_phase[k];
         if (bus.link_reset_i[k]) m_phase[k] = P_IDLE;
         else if (old == P_IDLE) begin
            if (m_opp[k] && all_r) m_phase[k] = P_REL;
            else if (any_r) m_phase[k] = P_WAIT;
         end else if (old == P_WAIT) begin
            if (m_opp[k] && all_r) m_phase[k] = P_REL;
            else if (!any_r) m_phase[k] = P_IDLE;
            else if (m_wrap) begin
               m_tmo[k]++;
               if (m_tmo[k] >= TIMEOUT_MF) m_phase[k] = P_ERR;
            end
         end else if (old == P_REL) begin
            if (members == 0) m_phase[k] = P_IDLE;
            else if (!all_r) m_phase[k] = P_ERR;
         end else begin
            if (!any_r) m_phase[k] = P_IDLE;
         end
         if (m_phase[k] != P_WAIT) m_tmo[k] = 0;
         if (bus.err_clr_i) begin
            m_err[k] = (m_phase[k] == P_ERR && old != P_ERR);
            m_cnt[k] = m_err[k] ? 1 : 0;
         end else if (m_phase[k] == P_ERR && old != P_ERR) begin
            m_err[k] = 1;
            m_cnt[k] = (m_cnt[k] + 1 > CNT_SAT) ? CNT_SAT : m_cnt[k] + 1;
         end
      end
      for (int k = 0; k < LINKS; k++) begin
         m_opp[k] = (bus.lmfc_counter_i == bus.release_delay_i[k*8 +: 8]);
      end
      m_wrap = (bus.lmfc_counter_i == 8'd0);
      for (int k = 0; k < LINKS; k++) begin
         e_state[k*2 +: 2]       = 2'(m_phase[k]);
         e_brn[k]                = (m_phase[k] != P_REL);
         e_valid[k]              = m_valid[k];
         e_err[k]                = m_err[k];
         e_cnt[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
      end
      for (int l = 0; l < L; l++) begin
         e_lane[l] = (lane_link(l) < 0) ? 1'b1 : (m_phase[lane_link(l)] != P_REL);
      end
      exp_q.push_back({e_state, e_brn, e_lane, e_valid, e_err, e_cnt});
   endtask

   task automatic compare_outputs();
      logic [LINKS*2-1:0]     e_state;
      logic [LINKS-1:0]       e_brn, e_valid, e_err;
      logic [L-1:0]           e_lane;
      logic [LINKS*CNT_W-1:0] e_cnt;
      {e_state, e_brn, e_lane, e_valid, e_err, e_cnt} = exp_q.pop_front();
      check_eq("link_state", 32'(bus.link_state_o), 32'(e_state));
      check_eq("buffer_release_n", 32'(bus.buffer_release_no), 32'(e_brn));
      check_eq("lane_release_n", 32'(bus.lane_release_no), 32'(e_lane));
      check_eq("link_valid", 32'(bus.link_valid_o), 32'(e_valid));
      check_eq("release_err", 32'(bus.release_err_o), 32'(e_err));
      check_eq("release_err_cnt", 32'(bus.release_err_cnt_o), 32'(e_cnt));
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_state"}, 32'(bus.link_state_o), 32'd0);
      check_eq({tag, "_brn"}, 32'(bus.buffer_release_no), 32'((1 << LINKS) - 1));
      check_eq({tag, "_lane"}, 32'(bus.lane_release_no), 32'((1 << L) - 1));
      check_eq({tag, "_valid"}, 32'(bus.link_valid_o), 32'd0);
      check_eq({tag, "_err"}, 32'(bus.release_err_o), 32'd0);
      check_eq({tag, "_cnt"}, 32'(bus.release_err_cnt_o), 32'd0);
   endtask

   // ---------------- driver tasks ----------------
   // Entered and left at a falling edge; inputs are changed only there.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1 compare_outputs();
      @(negedge clk);
      cyc++;
      bus.lmfc_counter_i = 8'(cyc % PERIOD);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic configure(input logic [L*LIW-1:0] map, input logic [L-1:0] en,
                            input logic [7:0] d0, input logic [7:0] d1);
      bus.link_reset_i = '1;
      bus.lane_link_map_i = map;
      bus.lane_enable_i = en;
      bus.release_delay_i = {d1, d0};
      run(2);
      bus.link_reset_i = '0;
   endtask

   initial begin
      rst = 1'b1;
      bus.lmfc_counter_i  = '0;
      bus.release_delay_i = '0;
      bus.lane_link_map_i = '0;
      bus.lane_enable_i   = '0;
      bus.buffer_ready_ni = '1;
      bus.link_reset_i    = '0;
      bus.err_clr_i       = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      // Two lanes on link 0, delay 3, both ready from the start.
      configure(4'b0000, 4'b0011, 8'd3, 8'd5);
      bus.buffer_ready_ni = 4'b1100;
      run(40);

      // Lanes 2,3 on link 1 (lane 3 never ready) and lanes 0,1 on link 0.
      // Link 1 is re-armed several times to saturate its counter; on the
      // last pass the clear lands on the timeout edge.
      configure(4'b1100, 4'b1111, 8'd3, 8'd6);
      bus.buffer_ready_ni = 4'b1000;
      for (int it = 0; it < 5; it++) begin
         bus.link_reset_i = 2'b10;
         tick();
         bus.link_reset_i = 2'b00;
         for (int c = 0; c < 45; c++) begin
            bus.err_clr_i = (it == 4) && (m_phase[1] == P_WAIT) &&
                            (m_tmo[1] == TIMEOUT_MF - 1) && m_wrap;
            tick();
         end
         bus.err_clr_i = 1'b0;
      end

      // Lane loss on link 0, recovery through IDLE, then re-release.
      bus.buffer_ready_ni[1] = 1'b1;
      tick();
      bus.buffer_ready_ni[1] = 1'b0;
      run(3);
      bus.buffer_ready_ni[1:0] = 2'b11;
      run(3);
      bus.buffer_ready_ni[1:0] = 2'b00;
      run(20);

      // Out-of-range delay times out; a sane delay plus link reset releases.
      configure(4'b0000, 4'b1111, 8'd200, 8'd0);
      bus.buffer_ready_ni = 4'b0000;
      run(50);
      bus.release_delay_i[7:0] = 8'd2;
      bus.link_reset_i = 2'b01;
      tick();
      bus.link_reset_i = 2'b00;
      run(20);

      // Randomized episodes.
      for (int ep = 0; ep < 40; ep++) begin
         logic [7:0] d [LINKS];
         for (int k = 0; k < LINKS; k++) begin
            d[k] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(PERIOD, 255))
                                               : 8'($urandom_range(0, PERIOD - 1));
         end
         configure((L*LIW)'($urandom), L'($urandom_range(1, (1 << L) - 1)), d[0], d[1]);
         bus.buffer_ready_ni = ($urandom_range(0, 2) == 0) ? L'($urandom) : '0;
         for (int c = 0; c < 50; c++) begin
            for (int l = 0; l < L; l++) begin
               if ($urandom_range(0, 29) == 0) bus.buffer_ready_ni[l] = ~bus.buffer_ready_ni[l];
               if ($urandom_range(0, 99) == 0) bus.lane_enable_i[l] = ~bus.lane_enable_i[l];
            end
            for (int k = 0; k < LINKS; k++) begin
               bus.link_reset_i[k] = ($urandom_range(0, 79) == 0);
            end
            bus.err_clr_i = ($urandom_range(0, 24) == 0);
            tick();
         end
         bus.err_clr_i = 1'b0;
         bus.link_reset_i = '0;
      end

      // Asynchronous reset while link 0 is released.
      configure(4'b0000, 4'b1111, 8'd1, 8'd4);
      bus.buffer_ready_ni = '0;
      for (int c = 0; c < 40 && m_phase[0] != P_REL; c++) tick();
      check_eq("reach_released", 32'(m_phase[0] == P_REL && bus.buffer_release_no[0] == 1'b0), 32'd1);
      @(posedge clk);
      model_step();
      #1 compare_outputs();
      #2 rst = 1'b1;
      #1 check_reset_values("async_reset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc++;
      bus.lmfc_counter_i = 8'(cyc % PERIOD);
      run(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard bound on total run time.
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "timeout");
   end
endmodule
